video_timing: RTL

Raster timing generator and output stage for the 1280x720 Pong display. Drives the signed `hpos`/`vpos` raster coordinates and the one-cycle `fsync` frame strobe consumed by the paddle, ball and other object blocks. Takes back the merged object pixel and `active` flag, and registers them with sync and data-enable to produce the video stream for the HDMI encoder.

---
 rtl/video_pkg.sv | 34 +++
 rtl/wrap_counter.sv | 38 +++
 rtl/video_timing.sv | 108 ++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// 720p60 timing constants and shared types for the raster generator.
package video_pkg;

    localparam int HRES_720   = 1280;
    localparam int VRES_720   = 720;
    localparam int H_FP_720   = 110;
    localparam int H_SYNC_720 = 40;
    localparam int H_BP_720   = 220;
    localparam int V_FP_720   = 5;
    localparam int V_SYNC_720 = 5;
    localparam int V_BP_720   = 20;

    localparam int RED   = 2;
    localparam int GREEN = 1;
    localparam int BLUE  = 0;

    typedef logic [23:0]        rgb_t;
    typedef logic signed [11:0] coord_t;

    // Blanking maps onto negative coordinates, so the counter minimum is
    // minus the total blanking width.
    function automatic coord_t blank_min(input int fp, input int sync, input int bp);
        return coord_t'(-(fp + sync + bp));
    endfunction

    function automatic coord_t hmin(input int fp, input int sync, input int bp);
        return blank_min(fp, sync, bp);
    endfunction

    function automatic coord_t vmin(input int fp, input int sync, input int bp);
        return blank_min(fp, sync, bp);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Signed up-counter that wraps from MAX back to MIN when enabled.
module wrap_counter
    import video_pkg::*;
#(
    parameter logic signed [11:0] MIN = -12'sd370,
    parameter logic signed [11:0] MAX = 12'sd1279
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic signed [11:0] count,
    output logic               wrap
);

    coord_t count_q;
    coord_t count_d;

    always_comb begin
        wrap    = en && (count_q == MAX);
        count_d = count_q;
        if (wrap) begin
            count_d = MIN;
        end else if (en) begin
            count_d = count_q + 12'sd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= MIN;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/video_timing.sv
// Raster timing generator and registered video output stage.
module video_timing
    import video_pkg::*;
#(
    parameter int   HRES     = HRES_720,
    parameter int   VRES     = VRES_720,
    parameter int   H_FP     = H_FP_720,
    parameter int   H_SYNC   = H_SYNC_720,
    parameter int   H_BP     = H_BP_720,
    parameter int   V_FP     = V_FP_720,
    parameter int   V_SYNC   = V_SYNC_720,
    parameter int   V_BP     = V_BP_720,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter rgb_t BG_COLOR = 24'h000000
) (
    input  logic               pixel_clk,
    input  logic               rst_n,
    output logic signed [11:0] hpos,
    output logic signed [11:0] vpos,
    output logic               fsync,
    input  logic [7:0]         obj_pixel [0:2],
    input  logic               obj_active,
    output logic [23:0]        vid_rgb,
    output logic               vid_hsync,
    output logic               vid_vsync,
    output logic               vid_de
);

    localparam coord_t HMIN     = hmin(H_FP, H_SYNC, H_BP);
    localparam coord_t VMIN     = vmin(V_FP, V_SYNC, V_BP);
    localparam coord_t HMAX     = coord_t'(HRES - 1);
    localparam coord_t VMAX     = coord_t'(VRES - 1);
    localparam coord_t HS_START = coord_t'(int'(HMIN) + H_FP);
    localparam coord_t HS_END   = coord_t'(int'(HMIN) + H_FP + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(int'(VMIN) + V_FP);
    localparam coord_t VS_END   = coord_t'(int'(VMIN) + V_FP + V_SYNC - 1);

    logic h_wrap;
    logic v_wrap;

    wrap_counter #(.MIN(HMIN), .MAX(HMAX)) u_hcnt (
        .clk   (pixel_clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .count (hpos),
        .wrap  (h_wrap)
    );

    wrap_counter #(.MIN(VMIN), .MAX(VMAX)) u_vcnt (
        .clk   (pixel_clk),
        .rst_n (rst_n),
        .en    (h_wrap),
        .count (vpos),
        .wrap  (v_wrap)
    );

    logic de_c;
    logic hs_c;
    logic vs_c;

    logic fsync_q,     fsync_d;
    rgb_t vid_rgb_q,   vid_rgb_d;
    logic vid_hsync_q, vid_hsync_d;
    logic vid_vsync_q, vid_vsync_d;
    logic vid_de_q,    vid_de_d;

    always_comb begin
        de_c = (hpos >= 12'sd0) && (vpos >= 12'sd0);
        hs_c = (hpos >= HS_START) && (hpos <= HS_END);
        vs_c = (vpos >= VS_START) && (vpos <= VS_END);

        // v_wrap already implies h_wrap: last pixel of the last line.
        fsync_d     = v_wrap;
        vid_de_d    = de_c;
        vid_hsync_d = hs_c ? HS_POL : ~HS_POL;
        vid_vsync_d = vs_c ? VS_POL : ~VS_POL;
        vid_rgb_d   = '0;
        if (de_c) begin
            vid_rgb_d = obj_active
                ? {obj_pixel[RED], obj_pixel[GREEN], obj_pixel[BLUE]}
                : BG_COLOR;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            fsync_q     <= 1'b0;
            vid_rgb_q   <= '0;
            vid_hsync_q <= ~HS_POL;
            vid_vsync_q <= ~VS_POL;
            vid_de_q    <= 1'b0;
        end else begin
            fsync_q     <= fsync_d;
            vid_rgb_q   <= vid_rgb_d;
            vid_hsync_q <= vid_hsync_d;
            vid_vsync_q <= vid_vsync_d;
            vid_de_q    <= vid_de_d;
        end
    end

    assign fsync     = fsync_q;
    assign vid_rgb   = vid_rgb_q;
    assign vid_hsync = vid_hsync_q;
    assign vid_vsync = vid_vsync_q;
    assign vid_de    = vid_de_q;

endmodule
